// File: rtl/mem_arb_pkg.sv
// Shared definitions for the DDR2 request arbiter: FSM encoding, field
// positions and bus widths used by the arbiter and its read-tag queue.
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arbState_t;

    localparam int OP_READ_BIT = 28;
    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 128;
    localparam int DEST_W      = 4;
    localparam int TAG_W       = DEST_W + 1;

    localparam logic [DEST_W-1:0] DC_DEST = 4'b0;

    // Read-tag word: destination core in the upper bits, display flag in bit 0.
    function automatic logic [TAG_W-1:0] packTag(input logic [DEST_W-1:0] dest,
                                                 input logic isDc);
        packTag = {dest, isDc};
    endfunction

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// In-order read-tag queue: first-word-fall-through FIFO holding one
// {dest, isDC} entry per outstanding read burst.
module mem_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] headData
);

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wrPtr_r;
    logic [AW-1:0]    rdPtr_r;
    logic [AW:0]      count_r;
    logic             pushOk_s;
    logic             popOk_s;

    // Pops while empty are dropped; a push at full is accepted only alongside a pop.
    always_comb begin
        popOk_s  = pop & (count_r != {(AW+1){1'b0}});
        pushOk_s = push & (~full | popOk_s);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (pushOk_s) wrPtr_r <= wrPtr_r + AW'(1);
            if (popOk_s)  rdPtr_r <= rdPtr_r + AW'(1);
            case ({pushOk_s, popOk_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage; contents are only observable through a non-empty head.
    always_ff @(posedge clock) begin
        if (pushOk_s) mem_r[wrPtr_r] <= pushData;
    end

    // Flags and gated head word.
    always_comb begin
        full     = (count_r == (AW+1)'(DEPTH));
        empty    = (count_r == {(AW+1){1'b0}});
        headData = empty ? {TAG_W{1'b0}} : mem_r[rdPtr_r];
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates DDR2 accesses between the ring memory-op queue and display
// reads, drives the controller AF/WB and tracks read-return ownership.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DC_MAX_RUN = 4,
    parameter int TAG_DEPTH  = 16,
    parameter int TAG_AW     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inhibit,
    input  logic              dcReq,
    input  logic [ADDR_W-1:0] dcAddr,
    output logic              dcAck,
    input  logic              opEmpty,
    input  logic [31:0]       opData,
    input  logic [DEST_W-1:0] opDest,
    output logic              rdOp,
    input  logic              wdEmpty,
    input  logic [DATA_W-1:0] wdData,
    output logic              rdWd,
    input  logic              afFull,
    input  logic              wbFull,
    output logic              wrAF,
    output logic [ADDR_W-1:0] afAddress,
    output logic              afRead,
    output logic              wrWB,
    output logic [DATA_W-1:0] wbData,
    input  logic              rdTag,
    output logic              tagEmpty,
    output logic [DEST_W-1:0] tagDest,
    output logic              tagDC
);

    localparam int RUN_W = $clog2(DC_MAX_RUN + 1);

    arbState_t         state_r, nextState_s;
    logic [RUN_W-1:0]  dcRun_r, nextDcRun_s;
    logic              tagFull_s;
    logic              canGrant_s, opIsRead_s;
    logic              dcElig_s, ringRdElig_s, ringWrElig_s, ringElig_s;
    logic              grantDc_s, grantRing_s;
    logic              wrAF_r, wrWB_r, afRead_r, isDc_r;
    logic [ADDR_W-1:0] afAddress_r;
    logic [DATA_W-1:0] wbData_r;
    logic [DEST_W-1:0] dest_r;
    logic [TAG_W-1:0]  tagHead_s;
    logic              unusedOpBits_s;

    assign unusedOpBits_s = &{1'b0, opData[31:29], opData[27:26]};
    assign opIsRead_s     = opData[OP_READ_BIT];

    // Grant decision and next-state; grants only from IDLE.
    always_comb begin
        nextState_s  = state_r;
        nextDcRun_s  = dcRun_r;
        canGrant_s   = (state_r == IDLE) & ~inhibit & ~afFull;
        dcElig_s     = canGrant_s & dcReq & ~tagFull_s;
        ringRdElig_s = canGrant_s & ~opEmpty & opIsRead_s & ~tagFull_s;
        ringWrElig_s = canGrant_s & ~opEmpty & ~opIsRead_s & ~wdEmpty & ~wbFull;
        ringElig_s   = ringRdElig_s | ringWrElig_s;
        grantRing_s  = ringElig_s & (~dcElig_s | (dcRun_r == RUN_W'(DC_MAX_RUN)));
        grantDc_s    = dcElig_s & ~grantRing_s;
        case (state_r)
            IDLE: begin
                if (grantRing_s) begin
                    nextState_s = ISSUE;
                    nextDcRun_s = {RUN_W{1'b0}};
                end else if (grantDc_s) begin
                    nextState_s = ISSUE;
                    if (ringElig_s && (dcRun_r != RUN_W'(DC_MAX_RUN))) begin
                        nextDcRun_s = dcRun_r + RUN_W'(1);
                    end else if (ringElig_s) begin
                        nextDcRun_s = dcRun_r;
                    end else begin
                        nextDcRun_s = {RUN_W{1'b0}};
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            ISSUE:   nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
        dcAck = grantDc_s;
        rdOp  = grantRing_s;
        rdWd  = grantRing_s & ~opIsRead_s;
    end

    // FSM state, run counter and the issue-cycle output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            dcRun_r     <= {RUN_W{1'b0}};
            wrAF_r      <= 1'b0;
            wrWB_r      <= 1'b0;
            afRead_r    <= 1'b0;
            isDc_r      <= 1'b0;
            afAddress_r <= {ADDR_W{1'b0}};
            wbData_r    <= {DATA_W{1'b0}};
            dest_r      <= {DEST_W{1'b0}};
        end else begin
            state_r <= nextState_s;
            dcRun_r <= nextDcRun_s;
            wrAF_r  <= grantDc_s | grantRing_s;
            wrWB_r  <= grantRing_s & ~opIsRead_s;
            if (grantDc_s) begin
                afAddress_r <= dcAddr;
                afRead_r    <= 1'b1;
                isDc_r      <= 1'b1;
                dest_r      <= DC_DEST;
            end else if (grantRing_s) begin
                afAddress_r <= opData[ADDR_W-1:0];
                afRead_r    <= opIsRead_s;
                isDc_r      <= 1'b0;
                dest_r      <= opDest;
                if (!opIsRead_s) wbData_r <= wdData;
            end
        end
    end

    mem_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .AW    (TAG_AW)
    ) tagQ (
        .clock    (clock),
        .reset    (reset),
        .push     (wrAF_r & afRead_r),
        .pushData (packTag(dest_r, isDc_r)),
        .pop      (rdTag),
        .full     (tagFull_s),
        .empty    (tagEmpty),
        .headData (tagHead_s)
    );

    assign wrAF      = wrAF_r;
    assign wrWB      = wrWB_r;
    assign afRead    = afRead_r;
    assign afAddress = afAddress_r;
    assign wbData    = wbData_r;
    assign tagDest   = tagHead_s[TAG_W-1:1];
    assign tagDC     = tagHead_s[0];

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter with hand-computed expectations.
module tb_mem_req_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         inhibit, dcReq, opEmpty, wdEmpty, afFull, wbFull, rdTag;
    logic [25:0]  dcAddr;
    logic [31:0]  opData;
    logic [3:0]   opDest;
    logic [127:0] wdData;
    logic         dcAck, rdOp, rdWd, wrAF, afRead, wrWB, tagEmpty, tagDC;
    logic [25:0]  afAddress;
    logic [127:0] wbData;
    logic [3:0]   tagDest;

    int totalCnt = 0;
    int badCnt   = 0;

    mem_req_arbiter dut (
        .clock(clock), .reset(reset), .inhibit(inhibit),
        .dcReq(dcReq), .dcAddr(dcAddr), .dcAck(dcAck),
        .opEmpty(opEmpty), .opData(opData), .opDest(opDest), .rdOp(rdOp),
        .wdEmpty(wdEmpty), .wdData(wdData), .rdWd(rdWd),
        .afFull(afFull), .wbFull(wbFull), .wrAF(wrAF), .afAddress(afAddress),
        .afRead(afRead), .wrWB(wrWB), .wbData(wbData),
        .rdTag(rdTag), .tagEmpty(tagEmpty), .tagDest(tagDest), .tagDC(tagDC)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        inhibit = 1'b0; dcReq = 1'b0; dcAddr = 26'h0;
        opEmpty = 1'b1; opData = 32'h0; opDest = 4'h0;
        wdEmpty = 1'b1; wdData = 128'h0;
        afFull = 1'b0; wbFull = 1'b0; rdTag = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic expDc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        idleInputs();
        reset = 1'b1;
        #1;
        checkVal("rst_tagEmpty", tagEmpty, 128'd1);
        checkVal("rst_wrAF", wrAF, 128'd0);
        checkVal("rst_afAddress", afAddress, 128'd0);
        checkVal("rst_afRead", afRead, 128'd0);
        checkVal("rst_wbData", wbData, 128'd0);
        checkVal("rst_tagDest", tagDest, 128'd0);
        checkVal("rst_tagDC", tagDC, 128'd0);
        doReset();

        // ring read
        opEmpty = 1'b0; opData = 32'h1000_0123; opDest = 4'd3;
        #1;
        checkVal("rd_rdOp", rdOp, 128'd1);
        checkVal("rd_rdWd", rdWd, 128'd0);
        checkVal("rd_dcAck", dcAck, 128'd0);
        step();
        opEmpty = 1'b1;
        #1;
        checkVal("rd_wrAF", wrAF, 128'd1);
        checkVal("rd_afAddress", afAddress, 128'h123);
        checkVal("rd_afRead", afRead, 128'd1);
        checkVal("rd_wrWB", wrWB, 128'd0);
        checkVal("rd_noRegrant", rdOp, 128'd0);
        step();
        checkVal("rd_tagEmpty", tagEmpty, 128'd0);
        checkVal("rd_tagDest", tagDest, 128'd3);
        checkVal("rd_tagDC", tagDC, 128'd0);
        checkVal("rd_wrAFdrop", wrAF, 128'd0);
        rdTag = 1'b1;
        step();
        rdTag = 1'b0;
        checkVal("rd_popEmpty", tagEmpty, 128'd1);

        // ring write
        opEmpty = 1'b0; opData = 32'h0000_0040; wdEmpty = 1'b0; wdData = {16{8'hA5}};
        #1;
        checkVal("wr_rdOp", rdOp, 128'd1);
        checkVal("wr_rdWd", rdWd, 128'd1);
        step();
        opEmpty = 1'b1; wdEmpty = 1'b1;
        #1;
        checkVal("wr_wrAF", wrAF, 128'd1);
        checkVal("wr_afRead", afRead, 128'd0);
        checkVal("wr_afAddress", afAddress, 128'h40);
        checkVal("wr_wrWB", wrWB, 128'd1);
        checkVal("wr_wbData", wbData, {16{8'hA5}});
        step();
        checkVal("wr_tagEmpty", tagEmpty, 128'd1);
        checkVal("wr_wrWBdrop", wrWB, 128'd0);

        // display run limit against a pending ring read
        doReset();
        opEmpty = 1'b0; opData = 32'h1000_0200; opDest = 4'd5;
        dcReq = 1'b1; dcAddr = 26'h300;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkVal($sformatf("run%0d_dcAck", i), dcAck, {127'd0, expDc[i]});
            checkVal($sformatf("run%0d_rdOp", i), rdOp, {127'd0, ~expDc[i]});
            step();
            if (!expDc[i]) opEmpty = 1'b1;
            checkVal($sformatf("run%0d_addr", i), afAddress, expDc[i] ? 128'h300 : 128'h200);
            step();
        end
        dcReq = 1'b0;
        checkVal("run_headDC", tagDC, 128'd1);

        // tag queue fill, block, pop and simultaneous push/pop
        doReset();
        opEmpty = 1'b0; opData = 32'h1000_0010;
        for (int i = 0; i < 16; i++) begin
            opDest = 4'(i);
            #1;
            checkVal($sformatf("fill%0d_rdOp", i), rdOp, 128'd1);
            step();
            step();
        end
        dcReq = 1'b1; opDest = 4'd9;
        #1;
        checkVal("full_noRdOp", rdOp, 128'd0);
        checkVal("full_noDcAck", dcAck, 128'd0);
        step();
        checkVal("full_noRdOp2", rdOp, 128'd0);
        dcReq = 1'b0;
        rdTag = 1'b1;
        step();
        rdTag = 1'b0;
        checkVal("pop_head", tagDest, 128'd1);
        checkVal("pop_rdOp", rdOp, 128'd1);
        step();
        rdTag = 1'b1;
        step();
        rdTag = 1'b0;
        checkVal("pushpop_head", tagDest, 128'd2);
        checkVal("pushpop_rdOp", rdOp, 128'd1);
        step();
        step();
        checkVal("refull_noRdOp", rdOp, 128'd0);

        // afFull / inhibit
        doReset();
        opEmpty = 1'b0; opData = 32'h1000_0077; afFull = 1'b1;
        #1;
        checkVal("afFull_rdOp", rdOp, 128'd0);
        step();
        checkVal("afFull_rdOp2", rdOp, 128'd0);
        afFull = 1'b0; inhibit = 1'b1; dcReq = 1'b1;
        #1;
        checkVal("inh_rdOp", rdOp, 128'd0);
        checkVal("inh_dcAck", dcAck, 128'd0);
        inhibit = 1'b0; dcReq = 1'b0;
        #1;
        checkVal("uninh_rdOp", rdOp, 128'd1);
        step();
        inhibit = 1'b1;
        #1;
        checkVal("inhIssue_wrAF", wrAF, 128'd1);
        step();
        checkVal("inhIssue_noGrant", rdOp, 128'd0);
        checkVal("inhIssue_wrAFdrop", wrAF, 128'd0);
        inhibit = 1'b0;

        // write stalled on empty writeDataQ, display bypass, reset in ISSUE
        doReset();
        opEmpty = 1'b0; opData = 32'h0000_0080; wdEmpty = 1'b1;
        dcReq = 1'b1; dcAddr = 26'h55;
        #1;
        checkVal("stall_dcAck", dcAck, 128'd1);
        checkVal("stall_rdOp", rdOp, 128'd0);
        step();
        dcReq = 1'b0;
        step();
        checkVal("stall_wait", rdOp, 128'd0);
        checkVal("stall_dcTag", tagDC, 128'd1);
        wdEmpty = 1'b0; wdData = {4{32'hDEAD_BEEF}};
        #1;
        checkVal("stall_go_rdOp", rdOp, 128'd1);
        checkVal("stall_go_rdWd", rdWd, 128'd1);
        step();
        opEmpty = 1'b1; wdEmpty = 1'b1;
        checkVal("stall_wrAF", wrAF, 128'd1);
        checkVal("stall_wrWB", wrWB, 128'd1);
        checkVal("stall_addr", afAddress, 128'h80);
        checkVal("stall_tagBusy", tagEmpty, 128'd0);
        reset = 1'b1;
        #1;
        checkVal("midrst_wrAF", wrAF, 128'd0);
        checkVal("midrst_wrWB", wrWB, 128'd0);
        checkVal("midrst_tagEmpty", tagEmpty, 128'd1);
        checkVal("midrst_afAddress", afAddress, 128'd0);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
